// File: rtl/tap_ram_arbiter.sv
// tap_ram_arbiter: shares the single-port tap coefficient BRAM between the
// AXI-Lite host (read/write) and the FIR engine coefficient fetch (read-only).
//
// Ports:
//   axis_clk, axis_rst_n             clock, async active-low reset
//   engine_busy                      1 = FIR running, engine gets priority
//   h_req/h_we/h_addr/h_wdata        host request (held until h_gnt)
//   h_gnt, h_rvalid, h_rdata         host grant, read data valid, read data
//   e_req/e_addr                     engine read request (held until e_gnt)
//   e_gnt, e_rvalid, e_rdata         engine grant, read data valid, read data
//   ram_EN/WE/A/Di, ram_Do           BRAM pins (Do valid 1 cycle after a read)
//
// Grants and RAM controls are combinational so a granted access reaches the
// BRAM in the same cycle; a starvation counter bounds host denials while the
// engine has priority.
module tap_ram_arbiter #(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned MAX_WAIT    = 4
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   engine_busy,
    input  logic                   h_req,
    input  logic                   h_we,
    input  logic [pADDR_WIDTH-1:0] h_addr,
    input  logic [pDATA_WIDTH-1:0] h_wdata,
    output logic                   h_gnt,
    output logic                   h_rvalid,
    output logic [pDATA_WIDTH-1:0] h_rdata,
    input  logic                   e_req,
    input  logic [pADDR_WIDTH-1:0] e_addr,
    output logic                   e_gnt,
    output logic                   e_rvalid,
    output logic [pDATA_WIDTH-1:0] e_rdata,
    output logic                   ram_EN,
    output logic [3:0]             ram_WE,
    output logic [pADDR_WIDTH-1:0] ram_A,
    output logic [pDATA_WIDTH-1:0] ram_Di,
    input  logic [pDATA_WIDTH-1:0] ram_Do
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        HOST_PRI = 2'd0,
        ENG_PRI  = 2'd1,
        STARVE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_HOST = 2'd1,
        RD_ENG  = 2'd2
    } owner_t;

    state_t                 state, state_next;
    logic [WAIT_W-1:0]      wait_cnt, wait_next;
    owner_t                 rd_owner;
    logic [pADDR_WIDTH-1:0] a_q;
    logic [pDATA_WIDTH-1:0] di_q;
    logic [pDATA_WIDTH-1:0] h_rdata_q;
    logic [pDATA_WIDTH-1:0] e_rdata_q;
    logic                   any_gnt;

    // State and starvation counter
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state    <= HOST_PRI;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // Grant selection and next state; grants are gated off during reset so
    // every output reads 0 while axis_rst_n is low
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        h_gnt      = 1'b0;
        e_gnt      = 1'b0;
        unique case (state)
            HOST_PRI: begin
                h_gnt = h_req;
                e_gnt = e_req && !h_req;
                if (engine_busy) state_next = ENG_PRI;
            end
            ENG_PRI: begin
                e_gnt = e_req;
                h_gnt = h_req && !e_req;
                if (h_req && !h_gnt && (wait_cnt != WAIT_MAX))
                    wait_next = wait_cnt + WAIT_W'(1);
                // Enter STARVE as soon as the denial count reaches the limit,
                // so the host is served on the very next cycle
                if (!engine_busy)
                    state_next = HOST_PRI;
                else if (h_req && !h_gnt && (wait_next == WAIT_MAX))
                    state_next = STARVE;
            end
            STARVE: begin
                h_gnt      = h_req;
                wait_next  = '0;
                state_next = engine_busy ? ENG_PRI : HOST_PRI;
            end
            default: begin
                state_next = HOST_PRI;
                wait_next  = '0;
            end
        endcase
        if (h_gnt || !engine_busy) wait_next = '0;
        if (!axis_rst_n) begin
            h_gnt = 1'b0;
            e_gnt = 1'b0;
        end
    end

    // Read ownership, last RAM address/data, held read data
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            rd_owner  <= RD_NONE;
            a_q       <= '0;
            di_q      <= '0;
            h_rdata_q <= '0;
            e_rdata_q <= '0;
        end else begin
            if (h_gnt && !h_we) rd_owner <= RD_HOST;
            else if (e_gnt)     rd_owner <= RD_ENG;
            else                rd_owner <= RD_NONE;
            if (any_gnt) begin
                a_q  <= ram_A;
                di_q <= ram_Di;
            end
            if (h_rvalid) h_rdata_q <= ram_Do;
            if (e_rvalid) e_rdata_q <= ram_Do;
        end
    end

    // RAM pin drive and read return muxing
    always_comb begin
        any_gnt  = h_gnt || e_gnt;
        ram_EN   = any_gnt;
        ram_WE   = (h_gnt && h_we) ? 4'hF : 4'h0;
        ram_A    = h_gnt ? h_addr : (e_gnt ? e_addr : a_q);
        ram_Di   = any_gnt ? h_wdata : di_q;
        h_rvalid = (rd_owner == RD_HOST);
        e_rvalid = (rd_owner == RD_ENG);
        h_rdata  = h_rvalid ? ram_Do : h_rdata_q;
        e_rdata  = e_rvalid ? ram_Do : e_rdata_q;
    end

endmodule
